// File: rtl/sccp_ff_pkg.sv
// Shared FF_TEST definitions: debounce FSM state encodings and the default qualification length.
package sccp_ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_e;

    // 1 ms at 50 MHz
    localparam int unsigned STABLE_CYCLES_DEF = 50000;
    localparam int unsigned CNT_W_DEF         = 16;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer with synchronous active-low reset, shared by the FF_TEST asynchronous inputs.
module sync2ff (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic sync
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronized input qualified for STABLE_CYCLES cycles, giving a clean LEVEL and edge pulses.
// Optional FALL pulse output is built when SW_DEBOUNCE_FALL_EN is defined.
module sw_debounce
    import sccp_ff_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic RISE,
`ifdef SW_DEBOUNCE_FALL_EN
    output logic FALL,
`endif
    output logic BUSY
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync2;
    db_state_e        state;
    logic [CNT_W-1:0] cnt;

    sync2ff u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (BTN_IN),
        .sync (sync2)
    );

    // Qualification FSM; pulses default low so they last exactly one cycle
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE_LO;
            cnt   <= '0;
            LEVEL <= 1'b0;
            RISE  <= 1'b0;
            BUSY  <= 1'b0;
`ifdef SW_DEBOUNCE_FALL_EN
            FALL  <= 1'b0;
`endif
        end else begin
            RISE <= 1'b0;
`ifdef SW_DEBOUNCE_FALL_EN
            FALL <= 1'b0;
`endif
            case (state)
                ST_IDLE_LO: begin
                    if (sync2) begin
                        state <= ST_WAIT_HI;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (!sync2) begin
                        state <= ST_IDLE_LO;
                        BUSY  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE_HI;
                        LEVEL <= 1'b1;
                        RISE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE_HI: begin
                    if (!sync2) begin
                        state <= ST_WAIT_LO;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (sync2) begin
                        state <= ST_IDLE_HI;
                        BUSY  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE_LO;
                        LEVEL <= 1'b0;
                        BUSY  <= 1'b0;
`ifdef SW_DEBOUNCE_FALL_EN
                        FALL  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4; build with SW_DEBOUNCE_FALL_EN to cover FALL.
module tb_sw_debounce;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic level, rise, busy;
`ifdef SW_DEBOUNCE_FALL_EN
    logic fall;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_debounce #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
        .CLK    (clk),
        .RST    (rst),
        .BTN_IN (btn),
        .LEVEL  (level),
        .RISE   (rise),
`ifdef SW_DEBOUNCE_FALL_EN
        .FALL   (fall),
`endif
        .BUSY   (busy)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive BTN_IN to val before edge k and follow a full qualification to acceptance at edge k+6
    task automatic transition(input logic val, input string tag);
        btn = val;
        for (int i = 0; i < 6; i++) begin
            tick();
            check({tag, "_level_hold"}, level, ~val);
            check({tag, "_rise_quiet"}, rise, 1'b0);
`ifdef SW_DEBOUNCE_FALL_EN
            check({tag, "_fall_quiet"}, fall, 1'b0);
`endif
            check({tag, "_busy"}, busy, (i >= 2));
        end
        tick();
        check({tag, "_level_new"}, level, val);
        check({tag, "_rise_pulse"}, rise, val);
`ifdef SW_DEBOUNCE_FALL_EN
        check({tag, "_fall_pulse"}, fall, ~val);
`endif
        check({tag, "_busy_done"}, busy, 1'b0);
        tick();
        check({tag, "_rise_end"}, rise, 1'b0);
`ifdef SW_DEBOUNCE_FALL_EN
        check({tag, "_fall_end"}, fall, 1'b0);
`endif
        check({tag, "_level_keep"}, level, val);
    endtask

    initial begin
        // Reset held 3 cycles with the button already pressed
        btn = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_level", level, 1'b0);
        check("rst_rise", rise, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef SW_DEBOUNCE_FALL_EN
        check("rst_fall", fall, 1'b0);
`endif
        rst = 1'b1;
        transition(1'b1, "rst_release");

        transition(1'b0, "release1");
        transition(1'b1, "press");
        transition(1'b0, "release2");

        // Bounce 1,0,1,0 then settle low
        for (int i = 0; i < 8; i++) begin
            btn = (i < 4) ? ~i[0] : 1'b0;
            tick();
            check("bounce_rise", rise, 1'b0);
            check("bounce_level", level, 1'b0);
        end
        check("bounce_busy_end", busy, 1'b0);

        // Late bounce: three synchronized highs, one low, then high
        btn = 1'b1;
        repeat (3) tick();
        btn = 1'b0;
        tick();
        btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("late_rise_quiet", rise, 1'b0);
            check("late_level_hold", level, 1'b0);
            if (i == 1) check("late_busy_drop", busy, 1'b0);
            if (i == 2) check("late_busy_restart", busy, 1'b1);
        end
        tick();
        check("late_rise_pulse", rise, 1'b1);
        check("late_level_new", level, 1'b1);
        tick();
        check("late_rise_end", rise, 1'b0);

        transition(1'b0, "release3");

        // Reset while a press is being qualified
        btn = 1'b1;
        repeat (4) tick();
        check("midwait_busy_pre", busy, 1'b1);
        rst = 1'b0;
        tick();
        check("midwait_busy", busy, 1'b0);
        check("midwait_level", level, 1'b0);
        check("midwait_rise", rise, 1'b0);
        btn = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_rise", rise, 1'b0);
            check("post_rst_level", level, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage that turns a raw, asynchronous, bouncing switch or push-button signal into a clean synchronous level and single-cycle edge pulses for the FF_TEST flip-flop stages. It sits directly upstream of the synchronous-reset D flip-flop: LEVEL or RISE drives that flop's D input on the same CLK/RST domain.

## Interface
- STABLE_CYCLES, 50000: consecutive synchronized cycles the input must hold a new value before it is accepted (1 ms at 50 MHz); legal range 1 .. 2^CNT_W-1
- CNT_W, 16: stability counter width
- CLK  input  1  system clock, all logic on posedge
- RST  input  1  reset, synchronous, active-low
- BTN_IN  input  1  raw asynchronous switch/button level
- LEVEL  output  1  debounced, registered level
- RISE  output  1  one-cycle pulse on accepted 0->1 transition
- FALL  output  1  one-cycle pulse on accepted 1->0 transition (present only with SW_DEBOUNCE_FALL_EN)
- BUSY  output  1  high while a candidate transition is being qualified

## Operation
- Two-flop synchronizer SYNC1 -> SYNC2 on BTN_IN; FSM and counter use SYNC2 only.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
- IDLE_LO: SYNC2=1 -> WAIT_HI, CNT<=0. Otherwise stay.
- WAIT_HI: SYNC2=0 -> IDLE_LO (bounce rejected, no pulse); SYNC2=1 and CNT==STABLE_CYCLES-1 -> IDLE_HI, LEVEL<=1, RISE<=1; else CNT<=CNT+1.
- IDLE_HI / WAIT_LO: mirror of the above with polarity inverted; acceptance sets LEVEL<=0, FALL<=1.
- RISE/FALL are registered and high for exactly one cycle; they deassert on the next edge unconditionally.
- BUSY = state is WAIT_HI or WAIT_LO (registered state decode).
- CNT is compared for equality only, never wraps: it is cleared on every WAIT entry and cannot exceed STABLE_CYCLES-1.
- Reset (RST=0 at a posedge): SYNC1, SYNC2, CNT = 0; state IDLE_LO; LEVEL, RISE, FALL, BUSY = 0. Reset has priority over all transitions.
- Reset mid-WAIT aborts qualification; no pulse is emitted.
- BTN_IN held high through reset release: it is treated as a fresh 0->1 and produces exactly one RISE after full qualification.

## Timing
- BTN_IN stable at its new value before edge k: SYNC2 updates at edge k+1; FSM enters WAIT at edge k+2; LEVEL and the pulse are asserted after edge k+2+STABLE_CYCLES.
- Total latency STABLE_CYCLES+3 edges counting edge k. With STABLE_CYCLES=1, acceptance happens on the edge after WAIT entry.
- Any SYNC2 glitch shorter than STABLE_CYCLES cycles during WAIT restarts qualification from IDLE.
- Minimum spacing between RISE and a following FALL is STABLE_CYCLES+1 cycles.

## Configuration
- SW_DEBOUNCE_FALL_EN defined: the FALL port and its register exist, and FALL pulses on the WAIT_LO->IDLE_LO acceptance.
- SW_DEBOUNCE_FALL_EN undefined: the FALL port and its register are absent. WAIT_LO->IDLE_LO still updates LEVEL and BUSY.

## Structure
- Shared package/header sccp_ff_pkg: 2-bit state encodings ST_IDLE_LO=0, ST_WAIT_HI=1, ST_IDLE_HI=2, ST_WAIT_LO=3, and the default STABLE_CYCLES constant.
- One sub-module, sync2ff: a 2-flop synchronizer with sync active-low RST, reused for other asynchronous inputs in FF_TEST.

## Test plan
Bench parameter: STABLE_CYCLES=4.
- Reset: RST=0 for 3 cycles with BTN_IN=1 -> LEVEL, RISE, FALL, BUSY all 0. Release -> RISE pulses once, LEVEL=1 at edge 6 after release.
- Clean press: BTN_IN 0->1 before edge k, held -> BUSY=1 from k+2; LEVEL=1 and RISE=1 after edge k+6. RISE=0 after k+7.
- Bounce: BTN_IN toggles 1,0,1,0 on consecutive cycles, then stays 0 -> no RISE, LEVEL stays 0, BUSY returns to 0.
- Late bounce: high for 3 synchronized cycles, then 1-cycle low, then high -> qualification restarts; RISE appears 4 cycles after the restart, not before.
- Release with SW_DEBOUNCE_FALL_EN: from LEVEL=1, BTN_IN->0 held -> FALL one-cycle pulse and LEVEL=0 after edge k+6. Without the macro: LEVEL=0 at the same edge.
- Reset mid-WAIT: RST=0 while BUSY=1 -> next edge BUSY=0, LEVEL=0, no RISE.
